prime_pair_sequencer: RTL and testbench

- Controller that drives the 8-bit primality checker to find two distinct primes (p, q) for toy RSA key generation.
- An internal 8-bit LFSR generates odd candidates. Each candidate at or above MIN_CAND gets a one-cycle start pulse and is held on the checker's num input until finish. Accepted primes are latched into p, then q.
- Sits between the key-generation top level and the single shared checker instance. It is the only block allowed to drive the checker's start/num.

---
 rtl/rsa_pkg.sv | 26 ++
 rtl/lfsr8.sv | 37 +++
 rtl/prime_pair_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_prime_pair_sequencer.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types and constants for toy RSA key generation.
// States, error codes and the 8-bit LFSR step used by lfsr8.
package rsa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GEN,
        ISSUE,
        WAIT,
        DONE,
        FAIL
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TRIES   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam logic [7:0] LFSR_ZERO_SUB = 8'hA5;
    // Feedback taps: bits 7, 5, 4, 3
    localparam logic [7:0] LFSR_TAPS     = 8'b1011_1000;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR with synchronous load and step enable.
// Ports: clk, rst_n, load, load_val, step -> state. A zero load becomes A5.
module lfsr8
    import rsa_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       step,
    output logic [7:0] state
);

    logic [7:0] state_d;
    logic [7:0] state_q;

    // Zero is the lock-up state, so it is never allowed in.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = (load_val == 8'h00) ? LFSR_ZERO_SUB : load_val;
        end else if (step) begin
            state_d = lfsr_next(state_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LFSR_ZERO_SUB;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/prime_pair_sequencer.sv
// Drives the shared primality checker to find two distinct primes p, q.
// Ports: start/seed in; chk_* handshake to checker; busy/done/fail/err_code,
// p/q with assume flags and tries out. All outputs are registered.
module prime_pair_sequencer
    import rsa_pkg::*;
#(
    parameter int MIN_CAND     = 11,
    parameter int MAX_TRIES    = 64,
    parameter int WAIT_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] seed,
    output logic       chk_start,
    output logic [7:0] chk_num,
    input  logic       chk_is_prime,
    input  logic       chk_finish,
    input  logic       chk_assume_prime,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [1:0] err_code,
    output logic [7:0] p,
    output logic [7:0] q,
    output logic       p_assumed,
    output logic       q_assumed,
    output logic [7:0] tries
);

    localparam int TW = $clog2(WAIT_TIMEOUT + 1);

    state_e          state_d, state_q;
    logic            chk_start_d, chk_start_q;
    logic [7:0]      chk_num_d, chk_num_q;
    logic            busy_d, busy_q;
    logic            done_d, done_q;
    logic            fail_d, fail_q;
    logic [1:0]      err_d, err_q;
    logic [7:0]      p_d, p_q;
    logic [7:0]      q_d, q_q;
    logic            pa_d, pa_q;
    logic            qa_d, qa_q;
    logic [7:0]      tries_d, tries_q;
    logic            found_d, found_q;
    logic [TW-1:0]   tmo_d, tmo_q;

    logic            lfsr_load;
    logic            lfsr_step;
    logic [7:0]      lfsr_s;
    logic [7:0]      cand;

    lfsr8 u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lfsr_load),
        .load_val (seed),
        .step     (lfsr_step),
        .state    (lfsr_s)
    );

    // Candidate is taken from the value the LFSR steps to this cycle.
    assign cand = lfsr_next(lfsr_s) | 8'h01;

    always_comb begin
        state_d     = state_q;
        chk_start_d = 1'b0;
        chk_num_d   = chk_num_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        fail_d      = 1'b0;
        err_d       = err_q;
        p_d         = p_q;
        q_d         = q_q;
        pa_d        = pa_q;
        qa_d        = qa_q;
        tries_d     = tries_q;
        found_d     = found_q;
        tmo_d       = tmo_q;
        lfsr_load   = 1'b0;
        lfsr_step   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    lfsr_load = 1'b1;
                    tries_d   = 8'd0;
                    err_d     = ERR_NONE;
                    p_d       = 8'd0;
                    q_d       = 8'd0;
                    pa_d      = 1'b0;
                    qa_d      = 1'b0;
                    found_d   = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = GEN;
                end
            end
            GEN: begin
                lfsr_step = 1'b1;
                // Small or duplicate candidates are skipped for free.
                if (cand >= 8'(MIN_CAND) && !(found_q && cand == p_q)) begin
                    chk_num_d = cand;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (tries_q == 8'(MAX_TRIES)) begin
                    err_d   = ERR_TRIES;
                    fail_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = FAIL;
                end else begin
                    chk_start_d = 1'b1;
                    tries_d     = tries_q + 8'd1;
                    tmo_d       = '0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (chk_finish) begin
                    if (!chk_is_prime) begin
                        state_d = GEN;
                    end else if (!found_q) begin
                        p_d     = chk_num_q;
                        pa_d    = chk_assume_prime;
                        found_d = 1'b1;
                        state_d = GEN;
                    end else begin
                        q_d     = chk_num_q;
                        qa_d    = chk_assume_prime;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end
                end else if (tmo_q == TW'(WAIT_TIMEOUT - 1)) begin
                    err_d   = ERR_TIMEOUT;
                    fail_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = FAIL;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            FAIL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            chk_start_q <= 1'b0;
            chk_num_q   <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            err_q       <= ERR_NONE;
            p_q         <= 8'd0;
            q_q         <= 8'd0;
            pa_q        <= 1'b0;
            qa_q        <= 1'b0;
            tries_q     <= 8'd0;
            found_q     <= 1'b0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            chk_start_q <= chk_start_d;
            chk_num_q   <= chk_num_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            err_q       <= err_d;
            p_q         <= p_d;
            q_q         <= q_d;
            pa_q        <= pa_d;
            qa_q        <= qa_d;
            tries_q     <= tries_d;
            found_q     <= found_d;
            tmo_q       <= tmo_d;
        end
    end

    assign chk_start = chk_start_q;
    assign chk_num   = chk_num_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign err_code  = err_q;
    assign p         = p_q;
    assign q         = q_q;
    assign p_assumed = pa_q;
    assign q_assumed = qa_q;
    assign tries     = tries_q;

endmodule

// File: tb/tb_prime_pair_sequencer.sv
// Bench for prime_pair_sequencer with a 5-cycle checker model.
// Expected chk_num values are queued per run and popped on each chk_start.
module tb_prime_pair_sequencer;

    localparam int MIN_CAND     = 11;
    localparam int MAX_TRIES    = 3;
    localparam int WAIT_TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] seed = 8'd0;
    logic       chk_start;
    logic [7:0] chk_num;
    logic       chk_is_prime;
    logic       chk_finish;
    logic       chk_assume_prime;
    logic       busy, done, fail;
    logic [1:0] err_code;
    logic [7:0] p, q, tries;
    logic       p_assumed, q_assumed;

    int n_cmp = 0;
    int n_bad = 0;

    // 0 true primality, 1 never prime, 2 always prime, 3 never finish
    int  mode = 0;
    bit  assume_p = 1'b0;
    int  prime_ans = 0;
    int  ans_base = 0;
    int  m_cnt;
    logic [7:0] m_num;
    int  pulses = 0;
    int  done_cnt = 0;
    int  fail_cnt = 0;
    logic [7:0] exp_q[$];

    prime_pair_sequencer #(
        .MIN_CAND     (MIN_CAND),
        .MAX_TRIES    (MAX_TRIES),
        .WAIT_TIMEOUT (WAIT_TIMEOUT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .seed             (seed),
        .chk_start        (chk_start),
        .chk_num          (chk_num),
        .chk_is_prime     (chk_is_prime),
        .chk_finish       (chk_finish),
        .chk_assume_prime (chk_assume_prime),
        .busy             (busy),
        .done             (done),
        .fail             (fail),
        .err_code         (err_code),
        .p                (p),
        .q                (q),
        .p_assumed        (p_assumed),
        .q_assumed        (q_assumed),
        .tries            (tries)
    );

    always #5 clk = ~clk;

    function automatic bit isp(input logic [7:0] n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= int'(n); d++) begin
            if (int'(n) % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0;
            m_num <= 8'd0;
        end else if (chk_start && mode != 3) begin
            m_cnt <= 5;
            m_num <= chk_num;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
        end
    end

    always @(posedge clk) begin
        if (chk_finish && chk_is_prime) prime_ans <= prime_ans + 1;
    end

    assign chk_finish   = (m_cnt == 1);
    assign chk_is_prime = chk_finish && (mode == 2 || (mode == 0 && isp(m_num)));
    assign chk_assume_prime = chk_is_prime && assume_p && (prime_ans == ans_base);

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (fail) fail_cnt++;
        if (rst_n && chk_start) begin
            pulses++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL chk_num: unexpected pulse got %0d", chk_num);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (chk_num !== e) begin
                    n_bad++;
                    $display("FAIL chk_num: got %0d want %0d", chk_num, e);
                end
            end
        end
    end

    task automatic model_run(input logic [7:0] s, input int md, input bit ap,
                             output logic [7:0] ep, output logic [7:0] eq,
                             output bit epa, output bit eqa,
                             output int et, output logic [1:0] ee);
        logic [7:0] l, c;
        int found;
        bit pr;
        l = (s == 8'h00) ? 8'hA5 : s;
        ep = 0; eq = 0; epa = 0; eqa = 0; et = 0; ee = 0; found = 0;
        for (int i = 0; i < 2000; i++) begin
            l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
            c = l | 8'h01;
            if (int'(c) < MIN_CAND) continue;
            if (found == 1 && c == ep) continue;
            if (et == MAX_TRIES) begin ee = 2'b01; break; end
            et++;
            exp_q.push_back(c);
            if (md == 3) begin ee = 2'b10; break; end
            pr = (md == 2) || (md == 0 && isp(c));
            if (pr) begin
                if (found == 0) begin
                    ep = c; epa = ap; found = 1;
                end else begin
                    eq = c; eqa = 1'b0; break;
                end
            end
        end
    endtask

    task automatic go(input logic [7:0] s);
        @(negedge clk);
        ans_base = prime_ans;
        seed  = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done || fail) begin ok = 1'b1; break; end
        end
        #1;
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL end_wait: no done/fail within bound");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({chk_start, busy, done, fail, p_assumed, q_assumed} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 0",
                     {chk_start, busy, done, fail, p_assumed, q_assumed});
        end
        n_cmp++;
        if ({chk_num, p, q, tries, err_code} !== 34'b0) begin
            n_bad++;
            $display("FAIL reset_vals: num %0d p %0d q %0d tries %0d err %0d want 0",
                     chk_num, p, q, tries, err_code);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_pair(input string nm, input logic [7:0] s, input int md,
                            input bit ap, input logic [7:0] fixed_p);
        logic [7:0] ep, eq;
        bit epa, eqa, ok;
        int et, p0;
        logic [1:0] ee;
        mode = md;
        assume_p = ap;
        exp_q.delete();
        model_run(s, md, ap, ep, eq, epa, eqa, et, ee);
        p0 = pulses;
        go(s);
        wait_end(ok);
        if (ok) begin
            n_cmp++;
            if (done !== 1'b1 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL %s done/busy: got %b%b want 10", nm, done, busy);
            end
            n_cmp++;
            if (p !== ep || p !== fixed_p) begin
                n_bad++;
                $display("FAIL %s p: got %0d want %0d", nm, p, ep);
            end
            n_cmp++;
            if (q !== eq || q === p) begin
                n_bad++;
                $display("FAIL %s q: got %0d want %0d (p %0d)", nm, q, eq, p);
            end
            n_cmp++;
            if (tries !== 8'(et) || pulses - p0 != et) begin
                n_bad++;
                $display("FAIL %s tries: got %0d pulses %0d want %0d",
                         nm, tries, pulses - p0, et);
            end
            n_cmp++;
            if ({p_assumed, q_assumed, err_code} !== {epa, eqa, ee}) begin
                n_bad++;
                $display("FAIL %s flags: got %b want %b", nm,
                         {p_assumed, q_assumed, err_code}, {epa, eqa, ee});
            end
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || exp_q.size() != 0) begin
                n_bad++;
                $display("FAIL %s done_pulse: done %b left %0d want 0 0",
                         nm, done, exp_q.size());
            end
        end
    endtask

    task automatic test_find_pair();
        run_pair("pair", 8'h01, 0, 1'b0, 8'd17);
    endtask

    task automatic test_dup_skip();
        // 7F steps to FF then FE: candidate 255 appears twice in a row.
        run_pair("dup", 8'h7F, 2, 1'b0, 8'd255);
        n_cmp++;
        if (q !== 8'd253 || tries !== 8'd2) begin
            n_bad++;
            $display("FAIL dup_fixed: q %0d tries %0d want 253 2", q, tries);
        end
    endtask

    task automatic test_assume();
        run_pair("assume", 8'h01, 0, 1'b1, 8'd17);
        n_cmp++;
        if ({p_assumed, q_assumed} !== 2'b10) begin
            n_bad++;
            $display("FAIL assume_fixed: got %b want 10", {p_assumed, q_assumed});
        end
    endtask

    task automatic test_tries();
        logic [7:0] ep, eq;
        bit epa, eqa, ok;
        int et, p0;
        logic [1:0] ee;
        mode = 1;
        assume_p = 1'b0;
        exp_q.delete();
        model_run(8'h01, 1, 1'b0, ep, eq, epa, eqa, et, ee);
        p0 = pulses;
        go(8'h01);
        wait_end(ok);
        if (ok) begin
            n_cmp++;
            if (fail !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
                n_bad++;
                $display("FAIL tries_end: fail %b busy %b done %b want 1 0 0",
                         fail, busy, done);
            end
            n_cmp++;
            if (err_code !== 2'b01 || ee !== 2'b01) begin
                n_bad++;
                $display("FAIL tries_err: got %b want 01", err_code);
            end
            n_cmp++;
            if (tries !== 8'd3 || pulses - p0 != 3) begin
                n_bad++;
                $display("FAIL tries_count: got %0d pulses %0d want 3",
                         tries, pulses - p0);
            end
            @(negedge clk);
            n_cmp++;
            if (fail !== 1'b0 || err_code !== 2'b01) begin
                n_bad++;
                $display("FAIL tries_hold: fail %b err %b want 0 01", fail, err_code);
            end
        end
    endtask

    task automatic test_timeout();
        logic [7:0] ep, eq;
        bit epa, eqa, seen;
        int et, n;
        logic [1:0] ee;
        mode = 3;
        exp_q.delete();
        model_run(8'h01, 3, 1'b0, ep, eq, epa, eqa, et, ee);
        go(8'h01);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (chk_start) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        n = 0;
        if (seen) begin
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                n++;
                if (fail) break;
            end
        end
        n_cmp++;
        if (!seen || n != WAIT_TIMEOUT || fail !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_cycles: seen %b got %0d want %0d",
                     seen, n, WAIT_TIMEOUT);
        end
        n_cmp++;
        if (err_code !== 2'b10 || tries !== 8'd1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_state: err %b tries %0d busy %b want 10 1 0",
                     err_code, tries, busy);
        end
        @(negedge clk);
    endtask

    task automatic test_busy_reset();
        logic [7:0] ep, eq;
        bit epa, eqa, seen;
        int et, d0, f0;
        logic [1:0] ee;
        mode = 0;
        assume_p = 1'b0;
        exp_q.delete();
        model_run(8'h01, 0, 1'b0, ep, eq, epa, eqa, et, ee);
        go(8'h01);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (chk_start) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        seed  = 8'h55;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (!seen || tries !== 8'd1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_start: seen %b tries %0d busy %b want 1 1 1",
                     seen, tries, busy);
        end
        d0 = done_cnt;
        f0 = fail_cnt;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({chk_start, busy, done, fail, p_assumed, q_assumed} !== 6'b0 ||
            {chk_num, p, q, tries, err_code} !== 34'b0) begin
            n_bad++;
            $display("FAIL async_reset: num %0d p %0d tries %0d busy %b want 0",
                     chk_num, p, tries, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        repeat (10) @(negedge clk);
        n_cmp++;
        if (done_cnt != d0 || fail_cnt != f0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_abort: done %0d fail %0d busy %b want 0 0 0",
                     done_cnt - d0, fail_cnt - f0, busy);
        end
        // Zero seed runs from A5: 75 rejected, then 149 and 43.
        run_pair("seed0", 8'h00, 0, 1'b0, 8'd149);
        n_cmp++;
        if (q !== 8'd43) begin
            n_bad++;
            $display("FAIL seed0_q: got %0d want 43", q);
        end
    endtask

    initial begin
        test_reset();
        test_find_pair();
        test_tries();
        test_timeout();
        test_dup_skip();
        test_assume();
        test_busy_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
